// File: rtl/tcp_rx_sched_cmd_buf_if.sv
// Scheduler command types and the handshake interface used by tcp_rx_sched_cmd_buf.
//   Package: set/clear field and the scheduler update command payload.
//   Interface: input command stream (src_*), output command stream (dst_*).
//     modport master : the buffer side (drives rdy upstream, val/cmd downstream)
//     modport slave  : the surrounding environment (RX datapath + scheduler)
package tcp_rx_sched_cmd_buf_pkg;

    localparam int unsigned FLOWID_W = 16;
    localparam int unsigned TS_W     = 32;

    typedef enum logic [1:0] {
        SC_NOP   = 2'd0,
        SC_SET   = 2'd1,
        SC_CLEAR = 2'd2
    } set_clear_e;

    typedef struct packed {
        set_clear_e          cmd;
        logic [TS_W-1:0]     timestamp;
    } set_clear_t;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        set_clear_t          rt;
        set_clear_t          ack;
        set_clear_t          data;
    } sched_cmd_struct;

endpackage

interface tcp_rx_sched_cmd_buf_if;
    import tcp_rx_sched_cmd_buf_pkg::*;

    logic            src_buf_sched_cmd_val;
    sched_cmd_struct src_buf_sched_cmd;
    logic            buf_src_sched_cmd_rdy;
    logic            buf_dst_sched_cmd_val;
    sched_cmd_struct buf_dst_sched_cmd;
    logic            dst_buf_sched_cmd_rdy;

    modport master (
        input  src_buf_sched_cmd_val,
        input  src_buf_sched_cmd,
        output buf_src_sched_cmd_rdy,
        output buf_dst_sched_cmd_val,
        output buf_dst_sched_cmd,
        input  dst_buf_sched_cmd_rdy
    );

    modport slave (
        output src_buf_sched_cmd_val,
        output src_buf_sched_cmd,
        input  buf_src_sched_cmd_rdy,
        input  buf_dst_sched_cmd_val,
        input  buf_dst_sched_cmd,
        output dst_buf_sched_cmd_rdy
    );

endinterface

// File: rtl/tcp_rx_sched_cmd_buf.sv
// Scheduler command buffer between the TCP RX datapath and the flow scheduler.
// Drops all-NOP commands, merges a command into the tail entry when the flow
// matches, otherwise pushes into a DEPTH-entry FIFO whose head drives the output.
//   clk, rst         : clock, asynchronous active-high reset
//   bus (master)     : src val/cmd in, src rdy out, dst val/cmd out, dst rdy in
//   buf_occupancy    : entries currently stored
//   buf_merge_cnt    : saturating count of merged input commands
//   buf_nop_drop_cnt : saturating count of discarded all-NOP commands
module tcp_rx_sched_cmd_buf
    import tcp_rx_sched_cmd_buf_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    tcp_rx_sched_cmd_buf_if.master bus,
    output logic [PTR_W:0]       buf_occupancy,
    output logic [31:0]          buf_merge_cnt,
    output logic [31:0]          buf_nop_drop_cnt
);

    localparam int unsigned CNT_W = PTR_W + 1;

    sched_cmd_struct mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             val_q;
    logic             rdy_q;

    logic             accept;
    logic             is_nop;
    logic             do_merge;
    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_nxt;
    sched_cmd_struct  in_cmd;
    sched_cmd_struct  tail_cmd;
    sched_cmd_struct  merged_cmd;

    // Classification of the incoming command and next occupancy
    always_comb begin
        in_cmd     = bus.src_buf_sched_cmd;
        tail_ptr   = wr_ptr - PTR_W'(1);
        tail_cmd   = mem[tail_ptr];
        accept     = bus.src_buf_sched_cmd_val && rdy_q;
        is_nop     = (in_cmd.rt.cmd == SC_NOP) && (in_cmd.ack.cmd == SC_NOP) &&
                     (in_cmd.data.cmd == SC_NOP);
        // count >= 2 keeps the merge target off the head entry being presented
        do_merge   = accept && !is_nop && (count >= CNT_W'(2)) &&
                     (in_cmd.flowid == tail_cmd.flowid);
        do_push    = accept && !is_nop && !do_merge;
        do_pop     = val_q && bus.dst_buf_sched_cmd_rdy;
        count_nxt  = count + CNT_W'(do_push) - CNT_W'(do_pop);

        merged_cmd = tail_cmd;
        if (in_cmd.rt.cmd   != SC_NOP) merged_cmd.rt   = in_cmd.rt;
        if (in_cmd.ack.cmd  != SC_NOP) merged_cmd.ack  = in_cmd.ack;
        if (in_cmd.data.cmd != SC_NOP) merged_cmd.data = in_cmd.data;
    end

    // Entry storage (not reset; only read where count says it is valid)
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_cmd;
        end else if (do_merge) begin
            mem[tail_ptr] <= merged_cmd;
        end
    end

    // Pointers, occupancy, registered handshake flags and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            val_q            <= 1'b0;
            rdy_q            <= 1'b0;
            buf_merge_cnt    <= '0;
            buf_nop_drop_cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            val_q <= (count_nxt != CNT_W'(0));
            rdy_q <= (count_nxt != CNT_W'(DEPTH));
            if (do_merge && (buf_merge_cnt != 32'hFFFF_FFFF)) begin
                buf_merge_cnt <= buf_merge_cnt + 32'd1;
            end
            if (accept && is_nop && (buf_nop_drop_cnt != 32'hFFFF_FFFF)) begin
                buf_nop_drop_cnt <= buf_nop_drop_cnt + 32'd1;
            end
        end
    end

    assign bus.buf_src_sched_cmd_rdy = rdy_q;
    assign bus.buf_dst_sched_cmd_val = val_q;
    assign bus.buf_dst_sched_cmd     = mem[rd_ptr];
    assign buf_occupancy             = count;

endmodule

// File: tb/tb_tcp_rx_sched_cmd_buf.sv
// Directed bench for tcp_rx_sched_cmd_buf: ordering, NOP drop, tail merge,
// no-merge on single entry, full FIFO back-pressure, asynchronous reset.
module tb_tcp_rx_sched_cmd_buf;
    import tcp_rx_sched_cmd_buf_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [3:0]  occ;
    logic [31:0] merge_cnt;
    logic [31:0] drop_cnt;

    int checks;
    int errors;

    tcp_rx_sched_cmd_buf_if bus ();

    tcp_rx_sched_cmd_buf #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.master),
        .buf_occupancy    (occ),
        .buf_merge_cnt    (merge_cnt),
        .buf_nop_drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic sched_cmd_struct mk(input logic [15:0] fid,
                                           input set_clear_e rc, input logic [31:0] rts,
                                           input set_clear_e ac, input logic [31:0] ats,
                                           input set_clear_e dc, input logic [31:0] dts);
        sched_cmd_struct c;
        c.flowid         = fid;
        c.rt.cmd         = rc;
        c.rt.timestamp   = rts;
        c.ack.cmd        = ac;
        c.ack.timestamp  = ats;
        c.data.cmd       = dc;
        c.data.timestamp = dts;
        return c;
    endfunction

    function automatic sched_cmd_struct ack_cmd(input logic [15:0] fid);
        return mk(fid, SC_NOP, 32'd0, SC_SET, 32'd0, SC_NOP, 32'd0);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input sched_cmd_struct c);
        bus.src_buf_sched_cmd_val = 1'b1;
        bus.src_buf_sched_cmd     = c;
        tick();
        bus.src_buf_sched_cmd_val = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.src_buf_sched_cmd_val = 1'b0;
        bus.src_buf_sched_cmd     = '0;
        bus.dst_buf_sched_cmd_rdy = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_val",   128'(bus.buf_dst_sched_cmd_val), 128'(1'b0));
        chk("rst_rdy",   128'(bus.buf_src_sched_cmd_rdy), 128'(1'b0));
        chk("rst_occ",   128'(occ), 128'(4'd0));
        chk("rst_merge", 128'(merge_cnt), 128'(32'd0));
        chk("rst_drop",  128'(drop_cnt), 128'(32'd0));
        rst = 1'b0;
        tick();
        chk("post_rst_rdy", 128'(bus.buf_src_sched_cmd_rdy), 128'(1'b1));

        // In-order flow with scheduler always ready
        bus.dst_buf_sched_cmd_rdy = 1'b1;
        bus.src_buf_sched_cmd_val = 1'b1;
        bus.src_buf_sched_cmd     = ack_cmd(16'd1);
        tick();
        chk("ord1_val", 128'(bus.buf_dst_sched_cmd_val), 128'(1'b1));
        chk("ord1_cmd", 128'(bus.buf_dst_sched_cmd), 128'(ack_cmd(16'd1)));
        bus.src_buf_sched_cmd = ack_cmd(16'd2);
        tick();
        chk("ord2_cmd", 128'(bus.buf_dst_sched_cmd), 128'(ack_cmd(16'd2)));
        chk("ord2_occ", 128'(occ), 128'(4'd1));
        bus.src_buf_sched_cmd = ack_cmd(16'd3);
        tick();
        chk("ord3_cmd", 128'(bus.buf_dst_sched_cmd), 128'(ack_cmd(16'd3)));
        bus.src_buf_sched_cmd_val = 1'b0;
        tick();
        chk("ord_empty_val", 128'(bus.buf_dst_sched_cmd_val), 128'(1'b0));
        chk("ord_empty_occ", 128'(occ), 128'(4'd0));

        // All-NOP command is dropped
        chk("nop_rdy", 128'(bus.buf_src_sched_cmd_rdy), 128'(1'b1));
        send(mk(16'd5, SC_NOP, 32'd3, SC_NOP, 32'd4, SC_NOP, 32'd5));
        chk("nop_val",  128'(bus.buf_dst_sched_cmd_val), 128'(1'b0));
        chk("nop_drop", 128'(drop_cnt), 128'(32'd1));
        chk("nop_occ",  128'(occ), 128'(4'd0));

        // Tail merge for the same flow
        bus.dst_buf_sched_cmd_rdy = 1'b0;
        send(ack_cmd(16'd4));
        send(mk(16'd7, SC_SET, 32'd10, SC_NOP, 32'd0, SC_NOP, 32'd0));
        send(mk(16'd7, SC_NOP, 32'd0, SC_SET, 32'd20, SC_NOP, 32'd0));
        chk("mrg_occ",   128'(occ), 128'(4'd2));
        chk("mrg_cnt",   128'(merge_cnt), 128'(32'd1));
        chk("mrg_head4", 128'(bus.buf_dst_sched_cmd), 128'(ack_cmd(16'd4)));
        bus.dst_buf_sched_cmd_rdy = 1'b1;
        tick();
        chk("mrg_head7", 128'(bus.buf_dst_sched_cmd),
            128'(mk(16'd7, SC_SET, 32'd10, SC_SET, 32'd20, SC_NOP, 32'd0)));
        tick();
        chk("mrg_empty", 128'(bus.buf_dst_sched_cmd_val), 128'(1'b0));

        // No merge into a lone head entry; head stays stable while stalled
        bus.dst_buf_sched_cmd_rdy = 1'b0;
        send(mk(16'd9, SC_NOP, 32'd0, SC_SET, 32'd5, SC_NOP, 32'd0));
        send(mk(16'd9, SC_SET, 32'd6, SC_NOP, 32'd0, SC_NOP, 32'd0));
        chk("nm_occ",   128'(occ), 128'(4'd2));
        chk("nm_merge", 128'(merge_cnt), 128'(32'd1));
        chk("nm_head",  128'(bus.buf_dst_sched_cmd),
            128'(mk(16'd9, SC_NOP, 32'd0, SC_SET, 32'd5, SC_NOP, 32'd0)));
        tick();
        tick();
        chk("nm_hold", 128'(bus.buf_dst_sched_cmd),
            128'(mk(16'd9, SC_NOP, 32'd0, SC_SET, 32'd5, SC_NOP, 32'd0)));
        chk("nm_hold_val", 128'(bus.buf_dst_sched_cmd_val), 128'(1'b1));
        bus.dst_buf_sched_cmd_rdy = 1'b1;
        tick();
        chk("nm_second", 128'(bus.buf_dst_sched_cmd),
            128'(mk(16'd9, SC_SET, 32'd6, SC_NOP, 32'd0, SC_NOP, 32'd0)));
        tick();
        chk("nm_empty", 128'(bus.buf_dst_sched_cmd_val), 128'(1'b0));

        // Fresh pointers for the full/wrap scenario
        bus.dst_buf_sched_cmd_rdy = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst2_merge", 128'(merge_cnt), 128'(32'd0));
        rst = 1'b0;
        tick();

        // Fill to DEPTH, refuse extra command, pop, refill across wrap
        for (int i = 0; i < DEPTH; i++) send(ack_cmd(16'(20 + i)));
        chk("full_occ", 128'(occ), 128'(4'd8));
        chk("full_rdy", 128'(bus.buf_src_sched_cmd_rdy), 128'(1'b0));
        send(mk(16'd27, SC_SET, 32'd99, SC_NOP, 32'd0, SC_NOP, 32'd0));
        chk("full_blk_occ",   128'(occ), 128'(4'd8));
        chk("full_blk_merge", 128'(merge_cnt), 128'(32'd0));
        bus.dst_buf_sched_cmd_rdy = 1'b1;
        tick();
        bus.dst_buf_sched_cmd_rdy = 1'b0;
        chk("pop1_occ", 128'(occ), 128'(4'd7));
        chk("pop1_rdy", 128'(bus.buf_src_sched_cmd_rdy), 128'(1'b1));
        send(ack_cmd(16'd28));
        chk("wrap_occ", 128'(occ), 128'(4'd8));
        bus.dst_buf_sched_cmd_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("wrap_order%0d", i), 128'(bus.buf_dst_sched_cmd),
                128'(ack_cmd(16'(21 + i))));
            tick();
        end
        chk("wrap_empty", 128'(bus.buf_dst_sched_cmd_val), 128'(1'b0));

        // Asynchronous reset in the middle of a cycle discards everything
        bus.dst_buf_sched_cmd_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(ack_cmd(16'(40 + i)));
        chk("ar_occ5", 128'(occ), 128'(4'd5));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_val", 128'(bus.buf_dst_sched_cmd_val), 128'(1'b0));
        chk("ar_occ", 128'(occ), 128'(4'd0));
        tick();
        rst = 1'b0;
        tick();
        send(ack_cmd(16'd50));
        chk("ar_new_head", 128'(bus.buf_dst_sched_cmd), 128'(ack_cmd(16'd50)));
        chk("ar_new_occ",  128'(occ), 128'(4'd1));
        bus.dst_buf_sched_cmd_rdy = 1'b1;
        tick();
        chk("ar_no_stale", 128'(bus.buf_dst_sched_cmd_val), 128'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
